// File: rtl/counter_pkg.sv
// Shared types and BCD digit arithmetic for the multi-button counter.
package counter_pkg;

    localparam int unsigned MAX_DIGITS = 16;

    typedef logic [3:0] digit_t;
    typedef digit_t [MAX_DIGITS-1:0] count_t;

    typedef enum logic [2:0] {
        STEP_NONE  = 3'd0,
        STEP_UP    = 3'd1,
        STEP_DOWN  = 3'd2,
        STEP_CLEAR = 3'd3,
        STEP_MODE  = 3'd4
    } step_e;

    // Returns {carry_out, digit}; a digit at 9 rolls to 0 with carry.
    function automatic logic [4:0] bcd_inc(input digit_t d, input logic cin);
        logic [4:0] r;
        if (!cin) begin
            r = {1'b0, d};
        end else if (d >= 4'd9) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

    // Returns {borrow_out, digit}; a digit at 0 rolls to 9 with borrow.
    function automatic logic [4:0] bcd_dec(input digit_t d, input logic bin);
        logic [4:0] r;
        if (!bin) begin
            r = {1'b0, d};
        end else if (d == 4'd0 || d > 4'd9) begin
            r = {1'b1, 4'd9};
        end else begin
            r = {1'b0, d - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, counter debounce and registered rising-edge press pulse
// for one asynchronous active-high button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d, stable_prev_q, press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count while the synchronised level disagrees with the accepted level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d    = '0;
            stable_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser, debounce state and press pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            sync1_q       <= btn_i;
            sync2_q       <= sync1_q;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/multi_button_counter.sv
// Multi-digit up/down counter in HEX or BCD, driven by four debounced buttons.
// Defining AUTO_REPEAT_EN adds hold-to-repeat on the up/down buttons.
module multi_button_counter
    import counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_clear,
    input  logic                    btn_mode,
    output logic [NUM_DIGITS*4-1:0] encoded,
    output logic [NUM_DIGITS-1:0]   digit_point,
    output logic                    dec_mode
);

    localparam int unsigned W = NUM_DIGITS * 4;

    logic                  up_p_s, down_p_s, clear_p_s, mode_p_s;
    logic                  up_lvl_s, down_lvl_s, clear_lvl_s, mode_lvl_s;
    logic                  rep_up_s, rep_down_s, up_ev_s, down_ev_s;
    step_e                 step_s;
    logic [W-1:0]          count_q, count_d, bcd_inc_s, bcd_dec_s;
    logic                  dec_mode_q, dec_mode_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .btn_i(btn_up), .level_o(up_lvl_s), .press_o(up_p_s));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .btn_i(btn_down), .level_o(down_lvl_s), .press_o(down_p_s));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk(clk), .reset(reset), .btn_i(btn_clear), .level_o(clear_lvl_s), .press_o(clear_p_s));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .btn_i(btn_mode), .level_o(mode_lvl_s), .press_o(mode_p_s));

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RW      = $clog2(RPT_MAX) + 1;

    logic          rep_active_q, rep_first_q;
    logic [RW-1:0] rep_cnt_q;
    logic          one_held_s, rep_kill_s, rep_start_s, rep_fire_s;
    logic          unused_lvl_s;

    assign unused_lvl_s = ^{clear_lvl_s, mode_lvl_s};
    // Repeat only while exactly one direction is stably held and nothing overrides it.
    assign one_held_s  = up_lvl_s ^ down_lvl_s;
    assign rep_kill_s  = clear_p_s | mode_p_s | ~one_held_s;
    assign rep_start_s = (up_p_s ^ down_p_s) & ~rep_kill_s;
    assign rep_fire_s  = rep_active_q & ~rep_kill_s &
                         (rep_cnt_q == (rep_first_q ? RW'(HOLD_CYCLES - 1) : RW'(REPEAT_CYCLES - 1)));
    assign rep_up_s    = rep_fire_s & up_lvl_s;
    assign rep_down_s  = rep_fire_s & down_lvl_s;

    // Repeat timer: long first interval after the press, then the short period.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_active_q <= 1'b0;
            rep_first_q  <= 1'b0;
            rep_cnt_q    <= '0;
        end else if (rep_start_s) begin
            rep_active_q <= 1'b1;
            rep_first_q  <= 1'b1;
            rep_cnt_q    <= '0;
        end else if (!rep_active_q || rep_kill_s) begin
            rep_active_q <= 1'b0;
            rep_first_q  <= 1'b0;
            rep_cnt_q    <= '0;
        end else if (rep_fire_s) begin
            rep_first_q  <= 1'b0;
            rep_cnt_q    <= '0;
        end else begin
            rep_cnt_q    <= rep_cnt_q + RW'(1);
        end
    end
`else
    logic unused_lvl_s;

    assign unused_lvl_s = ^{clear_lvl_s, mode_lvl_s, up_lvl_s, down_lvl_s,
                            (HOLD_CYCLES > REPEAT_CYCLES)};
    assign rep_up_s     = 1'b0;
    assign rep_down_s   = 1'b0;
`endif

    // Resolve the action for this cycle; up and down together cancel out.
    always_comb begin
        up_ev_s   = up_p_s | rep_up_s;
        down_ev_s = down_p_s | rep_down_s;
        if (clear_p_s) begin
            step_s = STEP_CLEAR;
        end else if (mode_p_s) begin
            step_s = STEP_MODE;
        end else if (up_ev_s && !down_ev_s) begin
            step_s = STEP_UP;
        end else if (down_ev_s && !up_ev_s) begin
            step_s = STEP_DOWN;
        end else begin
            step_s = STEP_NONE;
        end
    end

    // Per-digit BCD ripple increment and decrement of the current count.
    always_comb begin
        logic       c_inc, c_dec;
        logic [4:0] r;
        c_inc     = 1'b1;
        c_dec     = 1'b1;
        r         = 5'd0;
        bcd_inc_s = '0;
        bcd_dec_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r = bcd_inc(count_q[4*i +: 4], c_inc);
            bcd_inc_s[4*i +: 4] = r[3:0];
            c_inc = r[4];
            r = bcd_dec(count_q[4*i +: 4], c_dec);
            bcd_dec_s[4*i +: 4] = r[3:0];
            c_dec = r[4];
        end
    end

    // Next count, mode and decimal-point pattern.
    always_comb begin
        count_d    = count_q;
        dec_mode_d = dec_mode_q;
        case (step_s)
            STEP_CLEAR: count_d = '0;
            STEP_MODE: begin
                count_d    = '0;
                dec_mode_d = ~dec_mode_q;
            end
            STEP_UP:    count_d = dec_mode_q ? bcd_inc_s : count_q + W'(1);
            STEP_DOWN:  count_d = dec_mode_q ? bcd_dec_s : count_q - W'(1);
            default:    count_d = count_q;
        endcase
        dp_d    = '1;
        dp_d[0] = ~dec_mode_d;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            dec_mode_q <= 1'b0;
            dp_q       <= '1;
        end else begin
            count_q    <= count_d;
            dec_mode_q <= dec_mode_d;
            dp_q       <= dp_d;
        end
    end

    assign encoded     = count_q;
    assign digit_point = dp_q;
    assign dec_mode    = dec_mode_q;

endmodule

// File: tb/tb_multi_button_counter.sv
// Scoreboard bench: a value-level model predicts each output change and its cycle,
// a monitor checks every observed change against the queue.
module tb_multi_button_counter;

    localparam int ND   = 2;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic             clk = 1'b0;
    logic             reset, btn_up, btn_down, btn_clear, btn_mode;
    logic [ND*4-1:0]  encoded;
    logic [ND-1:0]    digit_point;
    logic             dec_mode;

    multi_button_counter #(
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_clear(btn_clear), .btn_mode(btn_mode),
        .encoded(encoded), .digit_point(digit_point), .dec_mode(dec_mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] enc;
        logic       dec;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    logic [8:0] prev_out = 9'h000;

    // Model state: plain integer value and mode flag.
    int m_val = 0;
    bit m_dec = 1'b0;

    function automatic logic [7:0] model_enc();
        int r = 0;
        int p = 1;
        if (!m_dec) return 8'(m_val);
        for (int i = 0; i < ND; i++) begin
            r += ((m_val / p) % 10) << (4 * i);
            p *= 10;
        end
        return 8'(r);
    endfunction

    // mask bits: {mode, clear, down, up}
    task automatic model_event(input logic [3:0] m, input int at);
        logic [7:0] old_enc;
        bit         old_dec;
        int         md;
        old_enc = model_enc();
        old_dec = m_dec;
        md      = m_dec ? 10 ** ND : 16 ** ND;
        if (m[2]) begin
            m_val = 0;
        end else if (m[3]) begin
            m_dec = ~m_dec;
            m_val = 0;
        end else if (m[0] ^ m[1]) begin
            m_val = m[0] ? (m_val + 1) % md : (m_val + md - 1) % md;
        end
        if (model_enc() != old_enc || m_dec != old_dec)
            exp_q.push_back('{model_enc(), m_dec, at});
    endtask

    // Monitor: every change of the outputs must match the next prediction.
    always @(negedge clk) begin
        if (mon_en && {encoded, dec_mode} !== prev_out) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: got enc=%h dec=%b at cycle %0d, required no change",
                         encoded, dec_mode, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (encoded !== mon_e.enc || dec_mode !== mon_e.dec ||
                    digit_point !== {1'b1, ~mon_e.dec} || cyc != mon_e.at) begin
                    fails++;
                    $display("FAIL change: got enc=%h dec=%b dp=%b cycle=%0d, required enc=%h dec=%b dp=%b cycle=%0d",
                             encoded, dec_mode, digit_point, cyc,
                             mon_e.enc, mon_e.dec, {1'b1, ~mon_e.dec}, mon_e.at);
                end
            end
        end
        prev_out = {encoded, dec_mode};
    end

    task automatic check_state(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_pending: %0d predicted changes not seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (encoded !== model_enc() || dec_mode !== m_dec || digit_point !== {1'b1, ~m_dec}) begin
            fails++;
            $display("FAIL %s_state: got enc=%h dec=%b dp=%b, required enc=%h dec=%b dp=%b",
                     name, encoded, dec_mode, digit_point, model_enc(), m_dec, {1'b1, ~m_dec});
        end
    endtask

    task automatic check_const(input string name, input logic [7:0] want);
        tests++;
        if (encoded !== want) begin
            fails++;
            $display("FAIL %s: got enc=%h, required %h", name, encoded, want);
        end
    endtask

    // Hold the buttons in mask m for n cycles, predicting press and repeat steps.
    task automatic press(input logic [3:0] m, input int n);
        int e0;
        @(negedge clk);
        e0 = cyc + 1;
        if (n >= DB) begin
            model_event(m, e0 + 2 + DB + 1);
`ifdef AUTO_REPEAT_EN
            if (m == 4'b0001 || m == 4'b0010)
                for (int t = 2 + DB + 1 + HOLD; t <= n + DB + 1; t += REP)
                    model_event(m, e0 + t);
`endif
        end
        {btn_mode, btn_clear, btn_down, btn_up} = m;
        repeat (n) @(negedge clk);
        {btn_mode, btn_clear, btn_down, btn_up} = 4'b0000;
        repeat (16) @(negedge clk);
    endtask

    logic [3:0] r_mask;
    int         r_sel;
    int         r_n;
    int         e0;

    initial begin
        reset = 1'b1;
        {btn_mode, btn_clear, btn_down, btn_up} = 4'b0000;
        repeat (3) @(negedge clk);
        tests++;
        if (encoded !== 8'h00 || dec_mode !== 1'b0 || digit_point !== 2'b11) begin
            fails++;
            $display("FAIL reset_state: got enc=%h dec=%b dp=%b, required enc=00 dec=0 dp=11",
                     encoded, dec_mode, digit_point);
        end
        reset  = 1'b0;
        mon_en = 1'b1;

        // Glitch rejection, then one accepted press with exact latency.
        press(4'b0001, 3);
        check_state("glitch");
        press(4'b0001, 10);
        check_state("first_press");
        check_const("first_press_value", 8'h01);

        // HEX wrap in both directions.
        press(4'b0100, 5);
        for (int i = 0; i < 255; i++) press(4'b0001, 4);
        check_state("hex_ff");
        check_const("hex_ff_value", 8'hFF);
        press(4'b0001, 5);
        check_const("hex_wrap_up", 8'h00);
        press(4'b0010, 5);
        check_state("hex_wrap_down");
        check_const("hex_wrap_down_value", 8'hFF);

        // Decimal mode carries and borrow.
        press(4'b1000, 5);
        check_state("dec_enter");
        for (int i = 0; i < 9; i++) press(4'b0001, 4);
        check_const("dec_09", 8'h09);
        press(4'b0001, 4);
        check_const("dec_carry", 8'h10);
        press(4'b0100, 4);
        press(4'b0010, 4);
        check_state("dec_borrow");
        check_const("dec_borrow_value", 8'h99);

        // Simultaneous buttons.
        press(4'b1000, 5);
        for (int i = 0; i < 5; i++) press(4'b0001, 4);
        press(4'b0011, 6);
        check_state("up_down_cancel");
        check_const("up_down_cancel_value", 8'h05);
        press(4'b0101, 6);
        check_state("clear_wins");

        // Long hold on up.
        press(4'b0001, 40);
        check_state("long_hold");
`ifdef AUTO_REPEAT_EN
        check_const("long_hold_value", 8'h05);
`else
        check_const("long_hold_value", 8'h01);
`endif

        // Randomised mix of buttons and hold lengths.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: r_mask = 4'b0001;
                3, 4:    r_mask = 4'b0010;
                5:       r_mask = 4'b0100;
                6:       r_mask = 4'b1000;
                7:       r_mask = 4'b0011;
                8:       r_mask = 4'b0101;
                default: r_mask = 4'b1010;
            endcase
            r_sel = $urandom_range(0, 7);
            if (r_sel == 0)      r_n = $urandom_range(1, 3);
            else if (r_sel == 1) r_n = $urandom_range(22, 45);
            else                 r_n = $urandom_range(4, 12);
            press(r_mask, r_n);
            check_state("random");
        end

        // Reset coinciding with an up pulse at 0x37 in decimal mode.
        if (!m_dec) press(4'b1000, 5);
        press(4'b0100, 5);
        for (int i = 0; i < 37; i++) press(4'b0001, 4);
        check_state("pre_reset");
        check_const("pre_reset_value", 8'h37);
        @(negedge clk);
        e0 = cyc + 1;
        m_val = 0;
        m_dec = 1'b0;
        exp_q.push_back('{8'h00, 1'b0, e0 + 2 + DB + 1});
        model_event(4'b0001, e0 + 2 + DB + 1 + 1 + 2 + DB + 1);
        btn_up = 1'b1;
        repeat (2 + DB + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        btn_up = 1'b0;
        repeat (16) @(negedge clk);
        check_state("reset_override");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at time limit, required to finish");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/multi_button_counter.md
MULTI_BUTTON_COUNTER -- requirements
Module: multi_button_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8; number of 4-bit count digits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000; clocks a synchronised button level must hold before it is accepted (minimum 2).
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000; clocks held before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_CYCLES, default 10_000_000; clocks between auto-repeat steps.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port btn_up  input  1  asynchronous increment button, active-high.
REQ-008 SHALL have port btn_down  input  1  asynchronous decrement button, active-high.
REQ-009 SHALL have port btn_clear  input  1  asynchronous clear button, active-high.
REQ-010 SHALL have port btn_mode  input  1  asynchronous HEX/DEC toggle button, active-high.
REQ-011 SHALL have port encoded  output  NUM_DIGITS*4  count; digit i occupies bits [4i+3:4i].
REQ-012 SHALL have port digit_point  output  NUM_DIGITS  active-low decimal points.
REQ-013 SHALL have port dec_mode  output  1  high when counting in decimal (BCD).

Function
REQ-014 SHALL synchronise each button through 2 flops, each resetting to 0.
REQ-015 SHALL debounce each button: a counter runs while the synchronised level differs from the stable level and clears when they match; the stable level flips when the counter reaches DEBOUNCE_CYCLES-1.
REQ-016 SHALL generate a 1-cycle press pulse on each 0->1 flip of a stable level; a 1->0 flip generates no pulse.
REQ-017 SHALL update encoded on the clock edge after a press pulse; a button held at 1 from a clean 0 changes encoded 2+DEBOUNCE_CYCLES+1 cycles after its first sampled 1.
REQ-018 In HEX mode, SHALL add or subtract 1 modulo 16^NUM_DIGITS: up from all-F gives 0, down from 0 gives all-F.
REQ-019 In DEC mode, SHALL do per-digit BCD ripple-carry and borrow modulo 10^NUM_DIGITS: up from all-9 gives 0, down from 0 gives all-9; no digit ever exceeds 9.
REQ-020 Pulse priority SHALL be clear > mode > up/down; up and down pulsing in the same cycle SHALL leave the count unchanged.
REQ-021 A clear pulse SHALL set encoded to 0.
REQ-022 A mode pulse SHALL toggle dec_mode and set encoded to 0.
REQ-023 digit_point SHALL be all-ones except bit 0, which equals ~dec_mode.

Reset
REQ-024 On reset, SHALL set encoded=0, dec_mode=0, digit_point all-ones, debounce counters=0, stable levels=0, and repeat timers idle.
REQ-025 Reset SHALL override any same-cycle pulse; a button held through reset SHALL produce exactly one pulse after debounce once reset deasserts.

Configuration
REQ-026 With macro AUTO_REPEAT_EN defined, SHALL repeat the up/down action while exactly one of up or down is stably held: the first repeat comes HOLD_CYCLES after its press pulse, then one every REPEAT_CYCLES.
REQ-027 With AUTO_REPEAT_EN defined, release, clear, mode, or both up and down held SHALL stop and rearm the repeat timer.
REQ-028 Without AUTO_REPEAT_EN, SHALL generate no repeat logic; only press pulses step the count.

Structure
REQ-029 SHALL place in package counter_pkg: the digit typedef (4-bit), the count-array typedef, and the bcd_inc and bcd_dec functions.
REQ-030 SHALL implement synchroniser, debounce and edge pulse in one sub-module, button_debounce, instantiated 4 times; all counting logic stays in the top module.

Verification
All scenarios use NUM_DIGITS=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
REQ-031 Glitch: btn_up high for 3 cycles, then low -> encoded stays 0x00; btn_up held 10 cycles -> encoded=0x01 at cycle 7 after its first sampled 1, exactly once.
REQ-032 HEX wrap: 255 up presses -> 0xFF; one more up press -> 0x00; one down press -> 0xFF.
REQ-033 DEC: mode press -> dec_mode=1, encoded=0x00, digit_point=2'b10; 9 up presses -> 0x09; 1 up press -> 0x10; down press from 0x00 -> 0x99.
REQ-034 Simultaneous: from 0x05, up and down released together -> 0x05; clear with up -> 0x00.
REQ-035 AUTO_REPEAT_EN: btn_up held 40 cycles after debounce -> steps at pulse, +20, +25, +30, +35, giving encoded=0x05; without the macro -> encoded=0x01.
REQ-036 Reset: assert reset at count 0x37 with btn_up pulse in the same cycle -> encoded=0x00 and dec_mode=0 next cycle.
